// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the number-conversion game round controller:
//   - state_t     : controller state encoding
//   - CNT_W       : width of the score and round counters
//   - level_mask(): difficulty level to target-mask lookup
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PLAY   = 3'd2,
    S_RESULT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int CNT_W = 4;

  // Higher levels expose more bits of the random value to convert.
  function automatic logic [7:0] level_mask(input logic [1:0] lvl);
    case (lvl)
      2'd0:    level_mask = 8'h03;
      2'd1:    level_mask = 8'h0F;
      2'd2:    level_mask = 8'h3F;
      default: level_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// Loadable down-counter. A load sets the count; otherwise it decrements and
// parks at zero. done is high whenever the count is zero, so loading N-1
// makes done appear in the N-th cycle after the load.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (count -> 0)
//   load       : load load_value this cycle (wins over decrement)
//   load_value : value to load
//   done       : count is zero
// -----------------------------------------------------------------------------
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0);

endmodule

// File: rtl/game_round_controller.sv
// -----------------------------------------------------------------------------
// game_round_controller
// Runs a game of NUM_ROUNDS rounds. Each round loads a masked random target,
// waits for the player's guess (or a timeout), then shows the result for
// RESULT_HOLD cycles. All outputs are registered.
// Ports:
//   clk, rst    : clock (rising edge) and synchronous active-high reset
//   start       : pulse, begins a game from IDLE or DONE
//   submit      : pulse, commits guess during PLAY
//   guess       : player switch value
//   level       : difficulty, sampled on an accepted start
//   rnd_in      : external free-running random value
//   target      : current number to convert
//   score       : correct answers this game (saturating)
//   round_idx   : current round, 0-based
//   playing, show_result, correct, timed_out, game_over : status flags
// -----------------------------------------------------------------------------
module game_round_controller
  import game_pkg::*;
#(
  parameter int NUM_ROUNDS     = 8,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int RESULT_HOLD    = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             submit,
  input  logic [7:0]       guess,
  input  logic [1:0]       level,
  input  logic [7:0]       rnd_in,
  output logic [7:0]       target,
  output logic [CNT_W-1:0] score,
  output logic [CNT_W-1:0] round_idx,
  output logic             playing,
  output logic             show_result,
  output logic             correct,
  output logic             timed_out,
  output logic             game_over
);

  localparam int MAX_CYC = (TIMEOUT_CYCLES > RESULT_HOLD) ? TIMEOUT_CYCLES : RESULT_HOLD;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0]    TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]    HOLD_LOAD    = TW'(RESULT_HOLD - 1);
  localparam logic [CNT_W-1:0] SCORE_MAX    = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] LAST_ROUND   = CNT_W'(NUM_ROUNDS - 1);

  state_t           r_state;
  logic [7:0]       r_mask;
  logic [7:0]       r_target;
  logic [CNT_W-1:0] r_score;
  logic [CNT_W-1:0] r_round;
  logic             r_playing;
  logic             r_show;
  logic             r_correct;
  logic             r_timed_out;
  logic             r_game_over;

  logic             w_timer_done;
  logic             w_timer_load;
  logic [TW-1:0]    w_timer_value;
  logic             w_hit;

  // One timer serves both phases: armed with the timeout while in LOAD, and
  // re-armed with the hold time on the edge that leaves PLAY.
  assign w_timer_load  = (r_state == S_LOAD) ||
                         ((r_state == S_PLAY) && (submit || w_timer_done));
  assign w_timer_value = (r_state == S_LOAD) ? TIMEOUT_LOAD : HOLD_LOAD;
  assign w_hit         = (guess == r_target);

  cycle_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (w_timer_load),
    .load_value(w_timer_value),
    .done      (w_timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_target    <= '0;
      r_score     <= '0;
      r_round     <= '0;
      r_playing   <= 1'b0;
      r_show      <= 1'b0;
      r_correct   <= 1'b0;
      r_timed_out <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_score     <= '0;
            r_round     <= '0;
            r_mask      <= level_mask(level);
            r_game_over <= 1'b0;
          end
        end

        S_LOAD: begin
          r_target  <= rnd_in & r_mask;
          r_playing <= 1'b1;
          r_state   <= S_PLAY;
        end

        S_PLAY: begin
          // submit is checked first so a same-cycle timeout resolves as a submit.
          if (submit) begin
            r_state     <= S_RESULT;
            r_playing   <= 1'b0;
            r_show      <= 1'b1;
            r_correct   <= w_hit;
            r_timed_out <= 1'b0;
            if (w_hit && (r_score < SCORE_MAX)) begin
              r_score <= r_score + 1'b1;
            end
          end else if (w_timer_done) begin
            r_state     <= S_RESULT;
            r_playing   <= 1'b0;
            r_show      <= 1'b1;
            r_correct   <= 1'b0;
            r_timed_out <= 1'b1;
          end
        end

        S_RESULT: begin
          if (w_timer_done) begin
            r_show      <= 1'b0;
            r_correct   <= 1'b0;
            r_timed_out <= 1'b0;
            if (r_round == LAST_ROUND) begin
              r_state     <= S_DONE;
              r_game_over <= 1'b1;
            end else begin
              r_round <= r_round + 1'b1;
              r_state <= S_LOAD;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign target      = r_target;
  assign score       = r_score;
  assign round_idx   = r_round;
  assign playing     = r_playing;
  assign show_result = r_show;
  assign correct     = r_correct;
  assign timed_out   = r_timed_out;
  assign game_over   = r_game_over;

endmodule

// File: tb/tb_game_round_controller.sv
// -----------------------------------------------------------------------------
// tb_game_round_controller
// Directed bench for game_round_controller with NUM_ROUNDS=3,
// TIMEOUT_CYCLES=10, RESULT_HOLD=4. Inputs change 1 ns after a rising edge
// and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_game_round_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       submit;
  logic [7:0] guess;
  logic [1:0] level;
  logic [7:0] rnd_in;
  logic [7:0] target;
  logic [3:0] score;
  logic [3:0] round_idx;
  logic       playing;
  logic       show_result;
  logic       correct;
  logic       timed_out;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  game_round_controller #(
    .NUM_ROUNDS    (3),
    .TIMEOUT_CYCLES(10),
    .RESULT_HOLD   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .submit     (submit),
    .guess      (guess),
    .level      (level),
    .rnd_in     (rnd_in),
    .target     (target),
    .score      (score),
    .round_idx  (round_idx),
    .playing    (playing),
    .show_result(show_result),
    .correct    (correct),
    .timed_out  (timed_out),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // {playing, show_result, correct, timed_out, game_over}
  function automatic logic [4:0] flags();
    return {playing, show_result, correct, timed_out, game_over};
  endfunction

  logic [7:0] game_rnd [3];

  initial begin
    game_rnd[0] = 8'h00;
    game_rnd[1] = 8'h5A;
    game_rnd[2] = 8'hC3;

    rst = 1'b1; start = 1'b0; submit = 1'b0;
    guess = 8'h00; level = 2'd0; rnd_in = 8'h00;
    tick(2);
    check("rst_target", target, 8'h00);
    check("rst_score",  score, 0);
    check("rst_round",  round_idx, 0);
    check("rst_flags",  flags(), 5'b00000);

    // Nothing moves without start.
    rst = 1'b0;
    tick(3);
    check("idle_hold_flags", flags(), 5'b00000);

    // Round 0: correct answer, level 1.
    level = 2'd1; rnd_in = 8'hA5; start = 1'b1;
    tick();                                   // -> LOAD
    start = 1'b0;
    check("load_not_playing", playing, 0);
    tick();                                   // -> PLAY
    check("r0_target", target, 8'h05);
    check("r0_playing", flags(), 5'b10000);
    rnd_in = 8'h3C;
    guess = 8'h05; submit = 1'b1;
    tick();                                   // -> RESULT cycle 1
    submit = 1'b0;
    check("r0_result_flags", flags(), 5'b01100);
    check("r0_score", score, 1);
    check("r0_target_hold", target, 8'h05);

    // start/submit during RESULT are ignored.
    start = 1'b1;
    tick();                                   // RESULT cycle 2
    start = 1'b0;
    check("res_start_ign_flags", flags(), 5'b01100);
    check("res_start_ign_score", score, 1);
    guess = 8'h00; submit = 1'b1;
    tick();                                   // RESULT cycle 3
    submit = 1'b0;
    check("res_submit_ign_flags", flags(), 5'b01100);
    tick();                                   // RESULT cycle 4
    check("res_c4_show", show_result, 1);
    check("res_c4_target", target, 8'h05);
    tick();                                   // -> LOAD, round 1
    check("r1_load_flags", flags(), 5'b00000);
    check("r1_round", round_idx, 1);

    // Round 1: timeout, with an ignored start during PLAY.
    guess = 8'h0C;
    tick();                                   // -> PLAY cycle 1
    check("r1_target", target, 8'h0C);
    start = 1'b1;
    tick();                                   // PLAY cycle 2
    start = 1'b0;
    check("play_start_ign_flags", flags(), 5'b10000);
    check("play_start_ign_round", round_idx, 1);
    tick(8);                                  // PLAY cycle 10
    check("r1_c10_playing", flags(), 5'b10000);
    tick();                                   // -> RESULT
    check("r1_timeout_flags", flags(), 5'b01010);
    check("r1_score", score, 1);
    tick(4);                                  // -> LOAD, round 2
    check("r2_load_flags", flags(), 5'b00000);
    check("r2_round", round_idx, 2);

    // Round 2: wrong submit on the 10th PLAY cycle resolves as a submit.
    rnd_in = 8'hFF;
    tick();                                   // -> PLAY cycle 1
    check("r2_target", target, 8'h0F);
    tick(9);                                  // PLAY cycle 10
    guess = 8'h00; submit = 1'b1;
    tick();                                   // -> RESULT
    submit = 1'b0;
    check("r2_simul_flags", flags(), 5'b01000);
    check("r2_score", score, 1);
    tick(4);                                  // -> DONE
    check("done_flags", flags(), 5'b00001);
    check("done_score", score, 1);
    check("done_round", round_idx, 2);
    tick(3);
    check("done_hold_target", target, 8'h0F);
    check("done_hold_flags", flags(), 5'b00001);

    // Full game of three correct rounds at level 3, restarted from DONE.
    level = 2'd3; start = 1'b1;
    tick();                                   // -> LOAD
    start = 1'b0;
    check("g2_score_clr", score, 0);
    check("g2_round_clr", round_idx, 0);
    check("g2_load_flags", flags(), 5'b00000);
    for (int r = 0; r < 3; r++) begin
      rnd_in = game_rnd[r];
      tick();                                 // -> PLAY
      check($sformatf("g2_r%0d_target", r), target, game_rnd[r]);
      guess = game_rnd[r]; submit = 1'b1;
      tick();                                 // -> RESULT
      submit = 1'b0;
      check($sformatf("g2_r%0d_correct", r), correct, 1);
      check($sformatf("g2_r%0d_score", r), score, r + 1);
      tick(4);
      if (r < 2) check($sformatf("g2_r%0d_next_round", r), round_idx, r + 1);
    end
    check("g2_game_over", game_over, 1);
    check("g2_final_score", score, 3);

    // Reset in the middle of round 1 of a new game, with start also high.
    level = 2'd0; rnd_in = 8'h07; start = 1'b1;
    tick();                                   // -> LOAD
    start = 1'b0;
    tick();                                   // -> PLAY
    check("g3_target", target, 8'h03);
    guess = 8'h03; submit = 1'b1;
    tick();                                   // -> RESULT
    submit = 1'b0;
    tick(4);                                  // -> LOAD, round 1
    tick();                                   // -> PLAY
    check("g3_pre_rst_score", score, 1);
    check("g3_pre_rst_round", round_idx, 1);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("mid_rst_target", target, 8'h00);
    check("mid_rst_score", score, 0);
    check("mid_rst_round", round_idx, 0);
    check("mid_rst_flags", flags(), 5'b00000);
    guess = 8'h00; submit = 1'b1;
    tick();
    submit = 1'b0;
    check("idle_submit_ign_flags", flags(), 5'b00000);
    check("idle_submit_ign_score", score, 0);
    tick(2);
    check("idle_after_rst_flags", flags(), 5'b00000);
    check("idle_after_rst_target", target, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_round_controller.md
GAME_ROUND_CONTROLLER -- requirements
Module: game_round_controller

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 8: rounds per game (1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000: maximum PLAY duration per round, in clk cycles.
REQ-003 SHALL have parameter RESULT_HOLD, default 25_000_000: RESULT display duration, in clk cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that begins a game.
REQ-007 SHALL have port submit, input, 1 bit: single-cycle pulse that commits the player's guess.
REQ-008 SHALL have port guess, input, 8 bits: player switch value.
REQ-009 SHALL have port level, input, 2 bits: difficulty, sampled only on an accepted start.
REQ-010 SHALL have port rnd_in, input, 8 bits: free-running LFSR value.
REQ-011 SHALL have port target, output, 8 bits: current number to convert.
REQ-012 SHALL have port score, output, 4 bits: correct answers this game.
REQ-013 SHALL have port round_idx, output, 4 bits: current round, 0-based.
REQ-014 SHALL have outputs playing, show_result, correct, timed_out and game_over, 1 bit each: status flags.

Function
REQ-015 SHALL implement states IDLE, LOAD, PLAY, RESULT, DONE.
REQ-016 Level mask SHALL be: 0 -> 8'h03, 1 -> 8'h0F, 2 -> 8'h3F, 3 -> 8'hFF; the mask is latched on an accepted start.
REQ-017 In IDLE or DONE, start SHALL move to LOAD next cycle, clear score and round_idx, and latch the mask.
REQ-018 start in LOAD, PLAY or RESULT SHALL be ignored.
REQ-019 LOAD SHALL last exactly one cycle, capture target <= rnd_in & mask, then enter PLAY.
REQ-020 A masked target of zero SHALL be legal.
REQ-021 On entering PLAY, the timeout counter SHALL be zero and playing SHALL be 1 throughout PLAY.
REQ-022 submit in PLAY at cycle M SHALL enter RESULT at M+1 with correct = (guess == target) and timed_out = 0.
REQ-023 When correct is set, score SHALL increment in the same cycle RESULT is entered.
REQ-024 If no submit arrives, the TIMEOUT_CYCLES-th PLAY cycle SHALL enter RESULT next cycle with correct = 0 and timed_out = 1.
REQ-025 submit and timeout in the same cycle SHALL resolve as a submit.
REQ-026 submit outside PLAY SHALL be ignored.
REQ-027 RESULT SHALL last exactly RESULT_HOLD cycles with show_result = 1, and correct/timed_out held stable.
REQ-028 At the end of RESULT: if round_idx == NUM_ROUNDS-1, SHALL enter DONE; otherwise SHALL increment round_idx and enter LOAD.
REQ-029 In DONE, game_over SHALL be 1; target, score and round_idx SHALL hold.
REQ-030 Score SHALL saturate at NUM_ROUNDS and never wrap.
REQ-031 correct and timed_out SHALL be 0 outside RESULT.
REQ-032 target SHALL change only in LOAD.

Reset
REQ-033 rst = 1 at a clock edge SHALL force IDLE with target = 0, score = 0, round_idx = 0, all flags 0 and counters 0, in any state including mid-round.
REQ-034 rst SHALL take priority over start and submit in the same cycle.
REQ-035 The first state change after rst deasserts SHALL require a start pulse.

Structure
REQ-036 Shared package game_pkg SHALL hold the state encodings, the level-to-mask table and the 4-bit score/round width constant.
REQ-037 SHALL contain one sub-module, cycle_timer: a loadable down-counter with a done flag, reused for timeout and hold.
REQ-038 SHALL NOT instantiate the LFSR; rnd_in is an external input.

Verification (NUM_ROUNDS=3, TIMEOUT_CYCLES=10, RESULT_HOLD=4)
REQ-039 Directed scenario, correct answer: level=1, rnd_in=8'hA5, start -> target=8'h05 two cycles later; guess=5, submit -> correct=1, score=1, show_result for 4 cycles, then LOAD with round_idx=1.
REQ-040 Directed scenario, timeout: no submit for 10 PLAY cycles -> timed_out=1, correct=0, score unchanged.
REQ-041 Directed scenario, simultaneous events: submit with wrong guess on the 10th PLAY cycle -> correct=0, timed_out=0.
REQ-042 Directed scenario, full game: 3 correct rounds -> game_over=1, score=3; start in DONE -> score=0, round_idx=0, LOAD next cycle.
REQ-043 Directed scenario, reset mid-operation: rst asserted mid-PLAY with start high the same cycle -> IDLE, all outputs 0 next cycle; submit afterwards ignored.
REQ-044 Directed scenario, ignored inputs: start pulses during PLAY/RESULT and submit during RESULT/IDLE -> no change in state, score or target.
